bats_pitch_encoder: RTL
=======================

# bats_pitch_encoder

Serializes order-book commands into a BATS PITCH 2.x binary byte stream, one message per sequenced unit. It is the inverse of the BATS parser: its byte output is drop-in stimulus for the parser's `data`/`data_valid` input, and its command input mirrors the parser's OrderBook command outputs. It sits between a market-data replay/generator source and the parser, or on the egress side of a feed simulator.

## Interface
Parameters:
- `UNIT`, 8'd1, PITCH unit number written into the sequenced unit header.
- `SEQ_INIT`, 32'd1, sequence number of the first unit after reset.

Ports:
- `Clk40Derived2x1I0MHz`  in  1  sole clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_code`  in  16  OrderBook command: 1=ADD, 2=EXECUTE, 3=REDUCE, 4=DELETE.
- `time_offset`  in  32  ns offset, copied into the message.
- `order_id`  in  64  order id.
- `side`  in  8  ASCII side, 'B' (0x42) or 'S' (0x53); passed through unchanged.
- `quantity`  in  32  ADD quantity.
- `symbol`  in  64  6 ASCII chars, left-justified in bits 63:16.
- `price`  in  64  ADD price.
- `executed_qty`  in  32  EXECUTE quantity.
- `exec_id`  in  64  EXECUTE execution id.
- `cancelled_qty`  in  32  REDUCE quantity.
- `data_out`  out  8  stream byte.
- `data_valid_out`  out  1  byte valid.
- `last_out`  out  1  final byte of the unit.
- `out_ready`  in  1  downstream accepts the byte when `data_valid_out && out_ready`.
- `bad_cmd`  out  1  one-cycle pulse when an unsupported `cmd_code` is accepted.

## Operation
- All command inputs are latched on accept; the sender may change them afterwards.
- Unit layout: 8-byte header, then the message. Header: Length u16 (8 + message length), Count u8 = 1, Unit u8, Sequence u32.
- Messages. The first byte is the length and the second is the type:
  - ADD → Add Order Long, 0x21, 34 B: len, type, time4, order_id8, side1, quantity4, symbol6, price8, flags1 = 0x00.
  - EXECUTE → Order Executed, 0x23, 26 B: len, type, time4, order_id8, executed_qty4, exec_id8.
  - REDUCE → Reduce Size Long, 0x25, 18 B: len, type, time4, order_id8, cancelled_qty4.
  - DELETE → Delete Order, 0x29, 14 B: len, type, time4, order_id8.
- Byte order: all numeric fields are little-endian. Symbol bytes are emitted `symbol[63:56]` first through `symbol[23:16]`.
- Unsupported `cmd_code`: the command is accepted, `bad_cmd` pulses the following cycle, no bytes are emitted, and the sequence number is unchanged.
- FSM states: IDLE, HEADER, BODY.
  - IDLE → HEADER on accepting a valid code.
  - HEADER → BODY after header byte 7 is accepted.
  - BODY → IDLE after the last byte is accepted.
- Byte index counter: 6 bits, reset to 0 on each state entry.
- Sequence register: 32 bits, reset to `SEQ_INIT`. It increments when the last byte of a unit is accepted and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values: `cmd_ready`=0 while `reset` is asserted, `data_out`=0x00, `data_valid_out`=0, `last_out`=0, `bad_cmd`=0, state=IDLE, sequence=`SEQ_INIT`.
- `cmd_ready` is high exactly in IDLE when not in reset.
- Latency: a command accepted at cycle N produces its first byte valid at N+1.
- Throughput: with `out_ready` held high, one byte per cycle. There is one idle cycle between units, because IDLE is revisited.
- Backpressure: while `data_valid_out && !out_ready`, `data_out` and `last_out` are held stable. `data_valid_out` never drops mid-unit.
- `last_out` is asserted together with the final byte only.
- Reset asserted mid-unit aborts the unit immediately. Outputs go to reset values and the sequence number returns to `SEQ_INIT`.

## Configuration
- `BATS_ENCODER_SEQ_HEADER_EN` defined: the 8-byte sequenced unit header is emitted as described above.
- Not defined: the HEADER state and the sequence register are removed. Output is bare messages (IDLE → BODY directly), and the first byte is valid at N+1.

## Structure
- Shared package `bats_pitch_pkg` holds:
  - command code constants, shared with the parser;
  - message type bytes (0x21/0x23/0x25/0x29) and message lengths (34/26/18/14);
  - header length 8;
  - the FSM state typedef.
- Sub-module `bats_pitch_byte_sel`: a combinational map from (latched fields, message type, byte index) to the output byte. The top level keeps the FSM, counters and handshake.

## Test plan
- DELETE, time_offset 0x10, order_id 0x0102030405060708, UNIT=1, sequence 1, out_ready=1 → 22 bytes:
  - 16 00 01 01 01 00 00 00 0E 29 10 00 00 00 08 07 06 05 04 03 02 01;
  - `last_out` on byte 22; the first byte appears 1 cycle after accept.
- ADD, side 'B', quantity 100, symbol "AAPL  ", price 0x1234 → header length 0x2A, body bytes 22 21 … 42 64 00 00 00 41 41 50 4C 20 20 34 12 00… 00. Then two back-to-back commands give sequences 1 and 2 with exactly one gap cycle.
- `out_ready` toggled pseudo-randomly during an EXECUTE → the byte sequence is identical to the stall-free run, and no byte changes while stalled.
- `cmd_code`=7 → `bad_cmd` pulses once, no `data_valid_out`, and the next DELETE still carries sequence 1.
- `SEQ_INIT`=0xFFFFFFFF, two units → sequence fields FF FF FF FF, then 00 00 00 00.
- Reset asserted at byte 5 of a REDUCE → `data_valid_out` drops at once, `cmd_ready` returns after deassert, and the next unit carries `SEQ_INIT`. Feeding the output into the parser yields the original command fields.

Source files
------------

// File: rtl/bats_pitch_pkg.sv
// Shared BATS PITCH 2.x definitions: command codes, message types/lengths,
// encoder FSM state and the latched command field bundle.
package bats_pitch_pkg;

  // OrderBook command codes, identical to the parser's command outputs
  localparam logic [15:0] CMD_ADD     = 16'd1;
  localparam logic [15:0] CMD_EXECUTE = 16'd2;
  localparam logic [15:0] CMD_REDUCE  = 16'd3;
  localparam logic [15:0] CMD_DELETE  = 16'd4;

  localparam logic [7:0] MSG_ADD_ORDER_LONG   = 8'h21;
  localparam logic [7:0] MSG_ORDER_EXECUTED   = 8'h23;
  localparam logic [7:0] MSG_REDUCE_SIZE_LONG = 8'h25;
  localparam logic [7:0] MSG_DELETE_ORDER     = 8'h29;

  localparam logic [5:0] LEN_ADD_ORDER_LONG   = 6'd34;
  localparam logic [5:0] LEN_ORDER_EXECUTED   = 6'd26;
  localparam logic [5:0] LEN_REDUCE_SIZE_LONG = 6'd18;
  localparam logic [5:0] LEN_DELETE_ORDER     = 6'd14;

  localparam logic [5:0] HDR_LEN = 6'd8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_BODY   = 2'd2
  } enc_state_t;

  typedef struct packed {
    logic [31:0] time_offset;
    logic [63:0] order_id;
    logic [7:0]  side;
    logic [31:0] quantity;
    logic [63:0] symbol;
    logic [63:0] price;
    logic [31:0] executed_qty;
    logic [63:0] exec_id;
    logic [31:0] cancelled_qty;
  } cmd_fields_t;

  // A zero type byte marks an unsupported command code
  function automatic logic [7:0] msg_type_of(input logic [15:0] code);
    case (code)
      CMD_ADD:     return MSG_ADD_ORDER_LONG;
      CMD_EXECUTE: return MSG_ORDER_EXECUTED;
      CMD_REDUCE:  return MSG_REDUCE_SIZE_LONG;
      CMD_DELETE:  return MSG_DELETE_ORDER;
      default:     return 8'h00;
    endcase
  endfunction

  function automatic logic [5:0] msg_len_of(input logic [7:0] msg_type);
    case (msg_type)
      MSG_ADD_ORDER_LONG:   return LEN_ADD_ORDER_LONG;
      MSG_ORDER_EXECUTED:   return LEN_ORDER_EXECUTED;
      MSG_REDUCE_SIZE_LONG: return LEN_REDUCE_SIZE_LONG;
      MSG_DELETE_ORDER:     return LEN_DELETE_ORDER;
      default:              return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/bats_pitch_byte_sel.sv
// Combinational byte map: picks the stream byte for the current header or
// message byte index out of the latched command fields.
module bats_pitch_byte_sel
  import bats_pitch_pkg::*;
#(
  parameter logic [7:0] UNIT = 8'd1
) (
  input  cmd_fields_t fields,
  input  logic [7:0]  msg_type,
  input  logic        in_header,
  input  logic [31:0] seq,
  input  logic [5:0]  idx,
  output logic [7:0]  byte_out
);

  logic [5:0]  msg_len;
  logic [15:0] unit_len;

  assign msg_len  = msg_len_of(msg_type);
  assign unit_len = {10'd0, msg_len} + {10'd0, HDR_LEN};

  // Little-endian byte i (only the low 3 bits of i matter) of a 64-bit value
  function automatic logic [7:0] le_byte(input logic [63:0] v, input logic [5:0] i);
    logic [63:0] s;
    s = v >> {i[2:0], 3'b000};
    return s[7:0];
  endfunction

  always_comb begin
    byte_out = 8'h00;
    if (in_header) begin
      case (idx)
        6'd0:    byte_out = unit_len[7:0];
        6'd1:    byte_out = unit_len[15:8];
        6'd2:    byte_out = 8'h01;
        6'd3:    byte_out = UNIT;
        default: byte_out = le_byte({32'h0, seq}, idx - 6'd4);
      endcase
    end else if (idx == 6'd0) begin
      byte_out = {2'b00, msg_len};
    end else if (idx == 6'd1) begin
      byte_out = msg_type;
    end else if (idx < 6'd6) begin
      byte_out = le_byte({32'h0, fields.time_offset}, idx - 6'd2);
    end else if (idx < 6'd14) begin
      byte_out = le_byte(fields.order_id, idx - 6'd6);
    end else begin
      case (msg_type)
        MSG_ADD_ORDER_LONG: begin
          if (idx == 6'd14)      byte_out = fields.side;
          else if (idx < 6'd19)  byte_out = le_byte({32'h0, fields.quantity}, idx - 6'd15);
          // symbol goes out most-significant character first
          else if (idx < 6'd25)  byte_out = le_byte(fields.symbol, 6'd26 - idx);
          else if (idx < 6'd33)  byte_out = le_byte(fields.price, idx - 6'd25);
          else                   byte_out = 8'h00;
        end
        MSG_ORDER_EXECUTED: begin
          if (idx < 6'd18)       byte_out = le_byte({32'h0, fields.executed_qty}, idx - 6'd14);
          else                   byte_out = le_byte(fields.exec_id, idx - 6'd18);
        end
        MSG_REDUCE_SIZE_LONG: begin
          byte_out = le_byte({32'h0, fields.cancelled_qty}, idx - 6'd14);
        end
        default: byte_out = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/bats_pitch_encoder.sv
// BATS PITCH 2.x encoder: order-book commands in, one sequenced unit per command out.
// Define BATS_ENCODER_SEQ_HEADER_EN to emit the 8-byte unit header and keep the sequence register.
module bats_pitch_encoder
  import bats_pitch_pkg::*;
#(
  parameter logic [7:0]  UNIT     = 8'd1,
  parameter logic [31:0] SEQ_INIT = 32'd1
) (
  input  logic        Clk40Derived2x1I0MHz,
  input  logic        reset,
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds valid and payload until that edge.
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_code,
  input  logic [31:0] time_offset,
  input  logic [63:0] order_id,
  input  logic [7:0]  side,
  input  logic [31:0] quantity,
  input  logic [63:0] symbol,
  input  logic [63:0] price,
  input  logic [31:0] executed_qty,
  input  logic [63:0] exec_id,
  input  logic [31:0] cancelled_qty,
  output logic [7:0]  data_out,
  output logic        data_valid_out,
  output logic        last_out,
  input  logic        out_ready,
  output logic        bad_cmd,
  output enc_state_t  dbg_state
);

  enc_state_t  state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  cmd_fields_t fields_q;
  logic [7:0]  type_q;
  logic        bad_q;

  logic [7:0]  acc_type;
  logic        accept;
  logic        fire;
  logic        last_byte;
  logic [5:0]  body_last;
  logic        in_header;
  logic [31:0] seq_val;
  logic [7:0]  sel_byte;

  assign acc_type  = msg_type_of(cmd_code);
  assign accept    = cmd_valid && cmd_ready;
  assign fire      = data_valid_out && out_ready;
  assign body_last = msg_len_of(type_q) - 6'd1;
  assign last_byte = (state_q == ST_BODY) && (idx_q == body_last);

`ifdef BATS_ENCODER_SEQ_HEADER_EN
  logic [31:0] seq_q;

  // Advances only when a unit fully leaves; wraps naturally at 32 bits
  always_ff @(posedge Clk40Derived2x1I0MHz or posedge reset) begin
    if (reset) begin
      seq_q <= SEQ_INIT;
    end else if (fire && last_byte) begin
      seq_q <= seq_q + 32'd1;
    end
  end

  assign in_header = (state_q == ST_HEADER);
  assign seq_val   = seq_q;
`else
  assign in_header = 1'b0;
  assign seq_val   = SEQ_INIT;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (acc_type != 8'h00)) begin
`ifdef BATS_ENCODER_SEQ_HEADER_EN
          state_d = ST_HEADER;
`else
          state_d = ST_BODY;
`endif
          idx_d = 6'd0;
        end
      end
      ST_HEADER: begin
        if (fire) begin
          if (idx_q == HDR_LEN - 6'd1) begin
            state_d = ST_BODY;
            idx_d   = 6'd0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      ST_BODY: begin
        if (fire) begin
          if (last_byte) begin
            state_d = ST_IDLE;
            idx_d   = 6'd0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge Clk40Derived2x1I0MHz or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= 6'd0;
      fields_q <= '0;
      type_q   <= 8'h00;
      bad_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bad_q   <= accept && (acc_type == 8'h00);
      if (accept && (acc_type != 8'h00)) begin
        type_q                 <= acc_type;
        fields_q.time_offset   <= time_offset;
        fields_q.order_id      <= order_id;
        fields_q.side          <= side;
        fields_q.quantity      <= quantity;
        fields_q.symbol        <= symbol;
        fields_q.price         <= price;
        fields_q.executed_qty  <= executed_qty;
        fields_q.exec_id       <= exec_id;
        fields_q.cancelled_qty <= cancelled_qty;
      end
    end
  end

  bats_pitch_byte_sel #(
    .UNIT (UNIT)
  ) u_byte_sel (
    .fields    (fields_q),
    .msg_type  (type_q),
    .in_header (in_header),
    .seq       (seq_val),
    .idx       (idx_q),
    .byte_out  (sel_byte)
  );

  // Outputs decode straight from registered state, so they hold while stalled
  assign cmd_ready      = (state_q == ST_IDLE) && !reset;
  assign data_valid_out = (state_q != ST_IDLE);
  assign data_out       = data_valid_out ? sel_byte : 8'h00;
  assign last_out       = last_byte;
  assign bad_cmd        = bad_q;
  assign dbg_state      = state_q;

endmodule
